// File: rtl/game_level_controller.sv
// game_level_controller
//   Top-level game sequencer: title -> level start -> playing -> result ->
//   (next level | game over | game won) -> title. Owns the per-level
//   countdown, per-level goal generation, the start_level launch pulse for
//   level_fsm, the saturating running total and the video screen select.
//
// Ports
//   clk              system clock
//   resetN           asynchronous active-low reset
//   startOfFrame     one-clk pulse per video frame (timer tick source)
//   is_enter_pressed enter key level, synchronous to clk
//   level_ended      level_fsm is in its end state
//   level_score      current level score from level_fsm
//   start_level      one-clk pulse launching level_fsm
//   timer_ended      level time expired
//   goal             score required to pass the current level
//   level_num        current level index, 0-based
//   time_left        seconds remaining in the level
//   total_score      saturating sum of passed-level scores
//   screen_sel       0 title, 1 playing, 2 game over, 3 game won
module game_level_controller #(
  parameter int unsigned FRAMES_PER_SEC = 30,
  parameter int unsigned LEVEL_TIME_SEC = 60,
  parameter int unsigned NUM_LEVELS     = 4,
  parameter int unsigned GOAL_BASE      = 20,
  parameter int unsigned GOAL_STEP      = 15
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        is_enter_pressed,
  input  logic        level_ended,
  input  logic [9:0]  level_score,
  output logic        start_level,
  output logic        timer_ended,
  output logic [9:0]  goal,
  output logic [2:0]  level_num,
  output logic [6:0]  time_left,
  output logic [12:0] total_score,
  output logic [1:0]  screen_sel
);

  localparam int unsigned SCORE_W  = 10;
  localparam int unsigned GOAL_W   = 10;
  localparam int unsigned LEVEL_W  = 3;
  localparam int unsigned TIME_W   = 7;
  localparam int unsigned TOTAL_W  = 13;
  localparam int unsigned SUM_W    = TOTAL_W + 1;
  localparam int unsigned SCREEN_W = 2;
  localparam int unsigned FRAME_W  = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  localparam int unsigned GOAL_MAX  = 1023;
  localparam int unsigned TOTAL_MAX = 8191;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(LEVEL_TIME_SEC);

  localparam logic [SCREEN_W-1:0] SCR_TITLE = 2'd0;
  localparam logic [SCREEN_W-1:0] SCR_PLAY  = 2'd1;
  localparam logic [SCREEN_W-1:0] SCR_OVER  = 2'd2;
  localparam logic [SCREEN_W-1:0] SCR_WON   = 2'd3;

  typedef enum logic [2:0] {
    TITLE_ST,
    LEVEL_START_ST,
    PLAYING_ST,
    RESULT_ST,
    GAME_OVER_ST,
    GAME_WON_ST
  } state_t;

  state_t               state_q,       state_d;
  logic                 enter_prev_q,  enter_prev_d;
  logic [FRAME_W-1:0]   frame_cnt_q,   frame_cnt_d;
  logic [TIME_W-1:0]    time_left_q,   time_left_d;
  logic                 timer_ended_q, timer_ended_d;
  logic [GOAL_W-1:0]    goal_q,        goal_d;
  logic [LEVEL_W-1:0]   level_num_q,   level_num_d;
  logic [TOTAL_W-1:0]   total_score_q, total_score_d;
  logic [SCORE_W-1:0]   score_lat_q,   score_lat_d;
  logic                 start_level_q, start_level_d;
  logic [SCREEN_W-1:0]  screen_sel_q,  screen_sel_d;

  logic                 enter_edge_c;
  logic [31:0]          goal_raw_c;
  logic [GOAL_W-1:0]    goal_sat_c;
  logic [SUM_W-1:0]     total_sum_c;
  logic [TOTAL_W-1:0]   total_sat_c;

  // Only a fresh press advances the flow; a held key is seen once.
  assign enter_edge_c = is_enter_pressed && !enter_prev_q;

  // Goal of the level about to start, clamped to the 10-bit goal range.
  always_comb begin
    goal_raw_c = GOAL_BASE + (32'(level_num_q) * GOAL_STEP);
    goal_sat_c = (goal_raw_c > GOAL_MAX) ? GOAL_W'(GOAL_MAX) : goal_raw_c[GOAL_W-1:0];
  end

  // Running total plus the latched level score, saturating at 13 bits.
  always_comb begin
    total_sum_c = SUM_W'(total_score_q) + SUM_W'(score_lat_q);
    total_sat_c = (total_sum_c > SUM_W'(TOTAL_MAX)) ? TOTAL_W'(TOTAL_MAX)
                                                     : total_sum_c[TOTAL_W-1:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    enter_prev_d  = is_enter_pressed;
    frame_cnt_d   = frame_cnt_q;
    time_left_d   = time_left_q;
    timer_ended_d = timer_ended_q;
    goal_d        = goal_q;
    level_num_d   = level_num_q;
    total_score_d = total_score_q;
    score_lat_d   = score_lat_q;
    start_level_d = 1'b0;

    case (state_q)
      TITLE_ST: begin
        if (enter_edge_c) begin
          level_num_d   = '0;
          total_score_d = '0;
          state_d       = LEVEL_START_ST;
        end
      end

      LEVEL_START_ST: begin
        goal_d        = goal_sat_c;
        time_left_d   = TIME_INIT;
        frame_cnt_d   = '0;
        timer_ended_d = 1'b0;
        start_level_d = 1'b1;
        state_d       = PLAYING_ST;
      end

      PLAYING_ST: begin
        // Countdown stops at zero; frames after expiry are ignored.
        if (startOfFrame && (time_left_q != '0)) begin
          if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            time_left_d = time_left_q - TIME_W'(1);
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end
        // Expiry flag lags the final decrement by one clk.
        if (time_left_q == '0) begin
          timer_ended_d = 1'b1;
        end
        // level_fsm's end state only counts once expiry is registered.
        if (timer_ended_q && level_ended) begin
          score_lat_d = level_score;
          state_d     = RESULT_ST;
        end
      end

      RESULT_ST: begin
        if (score_lat_q < goal_q) begin
          timer_ended_d = 1'b0;
          state_d       = GAME_OVER_ST;
        end else if (enter_edge_c) begin
          timer_ended_d = 1'b0;
          total_score_d = total_sat_c;
          if (level_num_q == LEVEL_LAST) begin
            state_d = GAME_WON_ST;
          end else begin
            level_num_d = level_num_q + LEVEL_W'(1);
            state_d     = LEVEL_START_ST;
          end
        end
      end

      GAME_OVER_ST, GAME_WON_ST: begin
        timer_ended_d = 1'b0;
        if (enter_edge_c) begin
          state_d = TITLE_ST;
        end
      end

      default: begin
        state_d = TITLE_ST;
      end
    endcase

    // Screen follows the state being entered so it is registered in step.
    case (state_d)
      TITLE_ST:     screen_sel_d = SCR_TITLE;
      GAME_OVER_ST: screen_sel_d = SCR_OVER;
      GAME_WON_ST:  screen_sel_d = SCR_WON;
      default:      screen_sel_d = SCR_PLAY;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= TITLE_ST;
      enter_prev_q  <= 1'b0;
      frame_cnt_q   <= '0;
      time_left_q   <= '0;
      timer_ended_q <= 1'b0;
      goal_q        <= '0;
      level_num_q   <= '0;
      total_score_q <= '0;
      score_lat_q   <= '0;
      start_level_q <= 1'b0;
      screen_sel_q  <= SCR_TITLE;
    end else begin
      state_q       <= state_d;
      enter_prev_q  <= enter_prev_d;
      frame_cnt_q   <= frame_cnt_d;
      time_left_q   <= time_left_d;
      timer_ended_q <= timer_ended_d;
      goal_q        <= goal_d;
      level_num_q   <= level_num_d;
      total_score_q <= total_score_d;
      score_lat_q   <= score_lat_d;
      start_level_q <= start_level_d;
      screen_sel_q  <= screen_sel_d;
    end
  end

  assign start_level = start_level_q;
  assign timer_ended = timer_ended_q;
  assign goal        = goal_q;
  assign level_num   = level_num_q;
  assign time_left   = time_left_q;
  assign total_score = total_score_q;
  assign screen_sel  = screen_sel_q;

endmodule

// File: tb/tb_game_level_controller.sv
// tb_game_level_controller
//   Randomized bench for game_level_controller. A stimulus process plays
//   whole games and pushes the events it expects (screen changes, level
//   launches, countdown steps, expiry) into queues; a monitor process pops
//   and compares them whenever the DUT shows the corresponding event.
module tb_game_level_controller;

  localparam int unsigned FPS = 30;
  localparam int unsigned LT  = 2;
  localparam int unsigned NL  = 2;
  localparam int unsigned GB  = 20;
  localparam int unsigned GS  = 15;

  localparam int unsigned SCR_TITLE = 0;
  localparam int unsigned SCR_PLAY  = 1;
  localparam int unsigned SCR_OVER  = 2;
  localparam int unsigned SCR_WON   = 3;

  typedef struct {
    int unsigned lvl;
    int unsigned goal;
    int unsigned tl;
    int unsigned tot;
    int unsigned cyc;
  } start_ev_t;

  typedef struct {
    int unsigned scr;
    int unsigned tot;
    int unsigned lvl;
  } screen_ev_t;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        is_enter_pressed;
  logic        level_ended;
  logic [9:0]  level_score;
  logic        start_level;
  logic        timer_ended;
  logic [9:0]  goal;
  logic [2:0]  level_num;
  logic [6:0]  time_left;
  logic [12:0] total_score;
  logic [1:0]  screen_sel;

  game_level_controller #(
    .FRAMES_PER_SEC (FPS),
    .LEVEL_TIME_SEC (LT),
    .NUM_LEVELS     (NL),
    .GOAL_BASE      (GB),
    .GOAL_STEP      (GS)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .is_enter_pressed (is_enter_pressed),
    .level_ended      (level_ended),
    .level_score      (level_score),
    .start_level      (start_level),
    .timer_ended      (timer_ended),
    .goal             (goal),
    .level_num        (level_num),
    .time_left        (time_left),
    .total_score      (total_score),
    .screen_sel       (screen_sel)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  start_ev_t   q_start[$];
  screen_ev_t  q_screen[$];
  int unsigned q_time[$];
  int unsigned q_timer[$];

  // Game model state
  int unsigned m_level;
  int unsigned m_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void miss(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected_event expected=no_event (cyc %0d)", name, cyc);
  endfunction

  function automatic int unsigned goal_of(input int unsigned lvl);
    int unsigned g;
    g = GB + lvl * GS;
    return (g > 1023) ? 1023 : g;
  endfunction

  function automatic int unsigned sat_total(input int unsigned a, input int unsigned b);
    return (a + b > 8191) ? 8191 : a + b;
  endfunction

  // Monitor: turns DUT output changes into events and scores them.
  initial begin
    int unsigned prev_screen;
    int unsigned prev_time;
    int unsigned zero_cyc;
    bit          prev_timer;
    start_ev_t   se;
    screen_ev_t  sc;
    int unsigned ex;
    prev_screen = 0;
    prev_time   = 0;
    prev_timer  = 0;
    zero_cyc    = 0;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        chk("start_level_in_reset", 32'(start_level), 0);
        prev_screen = 0;
        prev_time   = 0;
        prev_timer  = 0;
      end else begin
        if (start_level) begin
          if (q_start.size() == 0) miss("start_level_pulse");
          else begin
            se = q_start.pop_front();
            chk("start_level_num",   32'(level_num),   se.lvl);
            chk("start_goal",        32'(goal),        se.goal);
            chk("start_time_left",   32'(time_left),   se.tl);
            chk("start_total_score", 32'(total_score), se.tot);
            chk("start_latency_cyc", cyc,              se.cyc);
          end
        end else if (32'(time_left) != prev_time) begin
          if (q_time.size() == 0) miss("time_left_step");
          else begin
            ex = q_time.pop_front();
            chk("time_left_step", 32'(time_left), ex);
          end
          if (time_left == 7'd0) zero_cyc = cyc;
        end
        if (32'(screen_sel) != prev_screen) begin
          if (q_screen.size() == 0) miss("screen_change");
          else begin
            sc = q_screen.pop_front();
            chk("screen_sel",         32'(screen_sel),  sc.scr);
            chk("screen_total_score", 32'(total_score), sc.tot);
            chk("screen_level_num",   32'(level_num),   sc.lvl);
          end
        end
        if (timer_ended && !prev_timer) begin
          if (q_timer.size() == 0) miss("timer_ended_rise");
          else begin
            ex = q_timer.pop_front();
            chk("timer_ended_latency", cyc - zero_cyc, ex);
          end
        end
        prev_screen = 32'(screen_sel);
        prev_time   = 32'(time_left);
        prev_timer  = timer_ended;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start_level"}, 32'(start_level), 0);
    chk({tag, "_timer_ended"}, 32'(timer_ended), 0);
    chk({tag, "_goal"},        32'(goal),        0);
    chk({tag, "_level_num"},   32'(level_num),   0);
    chk({tag, "_time_left"},   32'(time_left),   0);
    chk({tag, "_total_score"}, 32'(total_score), 0);
    chk({tag, "_screen_sel"},  32'(screen_sel),  0);
  endtask

  task automatic press(input int unsigned hold);
    is_enter_pressed = 1'b1;
    repeat (hold) tick();
    is_enter_pressed = 1'b0;
    tick();
  endtask

  task automatic start_game();
    m_level = 0;
    m_total = 0;
    q_screen.push_back('{SCR_PLAY, 0, 0});
    q_start.push_back('{0, goal_of(0), LT, 0, cyc + 2});
    press($urandom_range(6, 1));
  endtask

  // Runs one level's countdown, then presents level_score via level_ended.
  task automatic play_level(input int unsigned score, input bit boundary);
    int unsigned pulses;
    int unsigned total_p;
    int unsigned g;
    pulses  = 0;
    total_p = FPS * LT;
    g       = goal_of(m_level);
    while (pulses < total_p) begin
      startOfFrame     = ($urandom_range(2) != 0);
      is_enter_pressed = 1'($urandom_range(1));
      level_ended      = ($urandom_range(7) == 0);
      level_score      = 10'($urandom_range(g - 1));
      if (startOfFrame) begin
        pulses++;
        if (pulses % FPS == 0) q_time.push_back(LT - pulses / FPS);
        if (pulses == total_p) begin
          q_timer.push_back(1);
          is_enter_pressed = 1'b0;
          if (boundary) begin
            level_ended = 1'b1;
            level_score = 10'(score);
          end else begin
            level_ended = 1'b0;
          end
        end
      end
      tick();
    end
    is_enter_pressed = 1'b0;
    repeat ($urandom_range(3)) begin
      startOfFrame = 1'($urandom_range(1));
      level_ended  = boundary;
      tick();
    end
    startOfFrame = 1'b0;
    level_ended  = 1'b1;
    level_score  = 10'(score);
    if (score < g) q_screen.push_back('{SCR_OVER, m_total, m_level});
    repeat (6) tick();
    level_ended = 1'b0;
    level_score = 10'($urandom_range(1023));
  endtask

  task automatic advance_after_pass(input int unsigned score, input int unsigned hold);
    m_total = sat_total(m_total, score);
    if (m_level == NL - 1) q_screen.push_back('{SCR_WON, m_total, m_level});
    else begin
      m_level++;
      q_start.push_back('{m_level, goal_of(m_level), LT, m_total, cyc + 2});
    end
    press(hold);
  endtask

  task automatic back_to_title();
    q_screen.push_back('{SCR_TITLE, m_total, m_level});
    press($urandom_range(4, 1));
  endtask

  initial begin
    int unsigned score;
    int unsigned n;
    bit          done;
    resetN           = 1'b0;
    startOfFrame     = 1'b0;
    is_enter_pressed = 1'b0;
    level_ended      = 1'b0;
    level_score      = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    resetN = 1'b1;
    tick();
    check_reset_outputs("idle_title");

    // Game 1: pass level 0 with 25, fail level 1 with 10.
    start_game();
    play_level(25, 1'b0);
    advance_after_pass(25, 3);
    play_level(10, 1'b1);
    back_to_title();

    // Game 2: pass both levels (30, 40) holding enter long at each press.
    start_game();
    play_level(30, 1'b1);
    advance_after_pass(30, 8);
    play_level(40, 1'b0);
    advance_after_pass(40, 12);
    chk("won_total_score", 32'(total_score), 70);
    chk("won_screen_held", 32'(screen_sel), SCR_WON);
    back_to_title();

    // Random games.
    repeat (4) begin
      start_game();
      done = 1'b0;
      while (!done) begin
        score = $urandom_range(2 * goal_of(m_level));
        play_level(score, 1'($urandom_range(1)));
        if (score < goal_of(m_level)) done = 1'b1;
        else begin
          done = (m_level == NL - 1);
          advance_after_pass(score, $urandom_range(6, 1));
        end
      end
      back_to_title();
    end

    // Asynchronous reset in the middle of a level.
    start_game();
    n = $urandom_range(FPS * LT - 2, FPS);
    for (int i = 1; i <= int'(n); i++) begin
      startOfFrame = 1'b1;
      level_ended  = 1'($urandom_range(1));
      if (i % FPS == 0) q_time.push_back(LT - i / FPS);
      tick();
    end
    startOfFrame = 1'b0;
    level_ended  = 1'b0;
    @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    check_reset_outputs("midlevel_reset");
    q_start.delete();
    q_screen.delete();
    q_time.delete();
    q_timer.delete();
    repeat (3) tick();
    resetN = 1'b1;
    tick();

    // Normal play resumes after reset.
    start_game();
    play_level(goal_of(0), 1'b0);
    advance_after_pass(goal_of(0), 2);
    play_level(0, 1'b0);
    back_to_title();

    repeat (10) tick();
    chk("pending_start_events",  q_start.size(),  0);
    chk("pending_screen_events", q_screen.size(), 0);
    chk("pending_time_events",   q_time.size(),   0);
    chk("pending_timer_events",  q_timer.size(),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_level_controller.md
Name: game_level_controller

Overview:
- Top-level game sequencer driving level_fsm.
- Runs the title, level, result, game-over and game-won flow.
- Owns the per-level countdown timer and per-level goal generation, and issues the start_level pulse.
- Accumulates the total score across levels and selects which screen the video mux shows.

Parameters:
- FRAMES_PER_SEC, 30, startOfFrame pulses per timer second.
- LEVEL_TIME_SEC, 60, countdown length per level in seconds, range 1..127.
- NUM_LEVELS, 4, number of levels, range 1..8.
- GOAL_BASE, 20, goal of level 0.
- GOAL_STEP, 15, goal increment per level.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-clk pulse per video frame.
- is_enter_pressed  in  1  enter key level, synchronous to clk.
- level_ended  in  1  from level_fsm; high while the level is in its end state.
- level_score  in  10  current level score from level_fsm.
- start_level  out  1  one-clk pulse that launches level_fsm.
- timer_ended  out  1  level time expired.
- goal  out  10  score required to pass the current level.
- level_num  out  3  current level index, 0-based.
- time_left  out  7  seconds remaining, for the HUD.
- total_score  out  13  sum of passed-level scores, saturating.
- screen_sel  out  2  0 = title, 1 = playing, 2 = game over, 3 = game won.

Behaviour:
- Reset values: state TITLE_ST, start_level 0, timer_ended 0, goal 0, level_num 0, time_left 0, total_score 0, screen_sel 0, frame counter 0, enter-edge register 0.
- Enter edge: enter_edge = is_enter_pressed && !enter_prev, with enter_prev registered every clk. Only enter_edge advances states; holding the key never skips more than one state.
- TITLE_ST: screen_sel = 0. On enter_edge, clear level_num and total_score, then go to LEVEL_START_ST.
- LEVEL_START_ST (exactly one clk):
  - goal <= min(GOAL_BASE + level_num*GOAL_STEP, 1023).
  - time_left <= LEVEL_TIME_SEC; frame_cnt <= 0; timer_ended <= 0.
  - start_level = 1 for this clk only.
  - Next state is PLAYING_ST.
- PLAYING_ST: screen_sel = 1.
  - On startOfFrame with time_left > 0:
    - If frame_cnt == FRAMES_PER_SEC-1, set frame_cnt <= 0 and time_left <= time_left-1.
    - Otherwise frame_cnt <= frame_cnt+1.
  - timer_ended is registered: set the clk after time_left becomes 0, then held high until the controller leaves RESULT_ST. time_left never wraps below 0.
  - level_ended is ignored while timer_ended = 0. With timer_ended = 1 and level_ended = 1, latch level_score into score_lat and go to RESULT_ST.
- RESULT_ST:
  - If score_lat < goal, go to GAME_OVER_ST in the next clk with no key required.
  - Otherwise wait for enter_edge. Then total_score <= min(total_score + score_lat, 8191).
    - If level_num == NUM_LEVELS-1, go to GAME_WON_ST.
    - Otherwise level_num++ and go to LEVEL_START_ST.
  - This matches level_fsm, which returns to idle on enter when its score is at or above goal.
- GAME_OVER_ST (screen_sel 2) and GAME_WON_ST (screen_sel 3): timer_ended cleared. On enter_edge, go to TITLE_ST. total_score and level_num hold until then.
- Boundary and simultaneous cases:
  - startOfFrame and enter_edge in the same clk are both processed, each in its own state's rules.
  - A 1-second boundary on the same clk as level_ended: level_ended is still ignored until timer_ended is registered.
  - Reset asserted mid-level returns every output to its reset value immediately (asynchronous). start_level is never emitted during reset.
- Latency:
  - Enter press in TITLE_ST: start_level high 2 clks after is_enter_pressed rises (1 clk edge detect, then LEVEL_START_ST).
  - Expiry: timer_ended rises 1 clk after the final decrement.

Test Plan:
- Reset, then assert enter in TITLE -> start_level is a single 1-clk pulse; goal = 20, time_left = 60, level_num = 0, screen_sel = 1.
- In PLAYING, 30 startOfFrame pulses -> time_left = 59. With LEVEL_TIME_SEC = 2, 60 pulses -> time_left = 0 and timer_ended = 1 on the next clk; further pulses leave time_left at 0.
- Timer expired, level_ended = 1, level_score = 25 with goal 20, then enter -> total_score = 25, level_num = 1, goal = 35, new start_level pulse.
- Timer expired, level_ended = 1, level_score = 10 with goal 20 -> GAME_OVER, screen_sel = 2 with no key needed; enter -> TITLE, screen_sel = 0.
- NUM_LEVELS = 2, pass both levels with scores 30 and 40 -> GAME_WON, screen_sel = 3, total_score = 70. Holding enter high continuously advances only one state per press.
- Drop resetN mid-PLAYING with time_left = 37 -> all outputs reset immediately. level_ended pulsed while timer_ended = 0 -> no state change.
